// File: rtl/matmul_pkg.sv
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and width constants for the matmul compute path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

  localparam int DEF_INW  = 12;
  localparam int DEF_M    = 7;
  localparam int DEF_N    = 9;
  localparam int DEF_MAXK = 8;

  localparam int K_BITS      = $clog2(DEF_MAXK + 1);
  localparam int A_ADDR_BITS = $clog2(DEF_M * DEF_MAXK);
  localparam int B_ADDR_BITS = $clog2(DEF_MAXK * DEF_N);
  localparam int OUTW        = 2 * DEF_INW + $clog2(DEF_MAXK);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    DRAIN    = 3'd2,
    OUT      = 3'd3,
    DONE     = 3'd4,
    WAIT_CLR = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/matmul_mac.sv
// ============================================================================
// Module      : matmul_mac
// Description : Signed multiply-accumulate; exposes the next accumulator value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_mac
  import matmul_pkg::*;
#(
  parameter int INW  = DEF_INW,
  parameter int OUTW = 2 * DEF_INW + $clog2(DEF_MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] acc_next
);

  logic signed [2*INW-1:0] w_prod;
  logic signed [OUTW-1:0]  r_acc;

  assign w_prod = a * b;

  always_comb begin
    acc_next = r_acc;
    if (clear)
      acc_next = '0;
    else if (en)
      acc_next = r_acc + OUTW'(w_prod);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_acc <= '0;
    else
      r_acc <= acc_next;
  end

endmodule

`default_nettype wire

// File: rtl/matmul_compute_ctrl.sv
// ============================================================================
// Module      : matmul_compute_ctrl
// Description : Sequences C = A x B, issuing memory reads and streaming results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_compute_ctrl
  import matmul_pkg::*;
#(
  parameter int  INW   = DEF_INW,
  parameter int  M     = DEF_M,
  parameter int  N     = DEF_N,
  parameter int  MAXK  = DEF_MAXK,
  localparam int OUT_W = 2 * INW + $clog2(MAXK),
  localparam int KW    = $clog2(MAXK + 1),
  localparam int AAW   = $clog2(M * MAXK),
  localparam int BAW   = $clog2(MAXK * N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    matrices_loaded,
  input  logic [KW-1:0]           K,
  output logic                    compute_finished,
  output logic [AAW-1:0]          A_read_addr,
  input  logic signed [INW-1:0]   A_data,
  output logic [BAW-1:0]          B_read_addr,
  input  logic signed [INW-1:0]   B_data,
  output logic signed [OUT_W-1:0] OUT_TDATA,
  output logic                    OUT_TVALID,
  input  logic                    OUT_TREADY
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  state_t                  r_state;
  logic [KW-1:0]           r_kval;
  logic [KW-1:0]           r_k;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  logic [AAW-1:0]          r_a_base;
  logic                    r_issue_d;
  logic                    w_clear;
  logic                    w_last;
  logic signed [OUT_W-1:0] w_acc_next;

  // Accumulator restarts whenever a new element is about to be issued.
  assign w_clear = (r_state == IDLE && matrices_loaded) ||
                   (r_state == OUT && OUT_TREADY);
  assign w_last  = (r_i == IW'(M - 1)) && (r_j == JW'(N - 1));

  matmul_mac #(
    .INW  (INW),
    .OUTW (OUT_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .en       (r_issue_d),
    .a        (A_data),
    .b        (B_data),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_kval           <= '0;
      r_k              <= '0;
      r_i              <= '0;
      r_j              <= '0;
      r_a_base         <= '0;
      r_issue_d        <= 1'b0;
      A_read_addr      <= '0;
      B_read_addr      <= '0;
      OUT_TDATA        <= '0;
      OUT_TVALID       <= 1'b0;
      compute_finished <= 1'b0;
    end else begin
      compute_finished <= 1'b0;
      r_issue_d        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (matrices_loaded) begin
            r_kval      <= K;
            r_k         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_a_base    <= '0;
            A_read_addr <= '0;
            B_read_addr <= '0;
            if (K == '0) begin
              OUT_TDATA  <= '0;
              OUT_TVALID <= 1'b1;
              r_state    <= OUT;
            end else begin
              r_state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          r_issue_d <= 1'b1;
          // Addresses stay on the last issued pair through DRAIN and OUT.
          if (r_k == r_kval - KW'(1)) begin
            r_state <= DRAIN;
          end else begin
            r_k         <= r_k + KW'(1);
            A_read_addr <= A_read_addr + AAW'(1);
            B_read_addr <= B_read_addr + BAW'(N);
          end
        end

        DRAIN: begin
          OUT_TDATA  <= w_acc_next;
          OUT_TVALID <= 1'b1;
          r_state    <= OUT;
        end

        OUT: begin
          if (OUT_TREADY) begin
            OUT_TVALID <= 1'b0;
            if (w_last) begin
              compute_finished <= 1'b1;
              r_state          <= DONE;
            end else begin
              r_k <= '0;
              if (r_j == JW'(N - 1)) begin
                r_j         <= '0;
                r_i         <= r_i + IW'(1);
                r_a_base    <= r_a_base + AAW'(r_kval);
                A_read_addr <= r_a_base + AAW'(r_kval);
                B_read_addr <= '0;
              end else begin
                r_j         <= r_j + JW'(1);
                A_read_addr <= r_a_base;
                B_read_addr <= BAW'(r_j) + BAW'(1);
              end
              if (r_kval == '0) begin
                OUT_TDATA  <= '0;
                OUT_TVALID <= 1'b1;
              end else begin
                r_state <= ISSUE;
              end
            end
          end
        end

        DONE: begin
          r_state <= WAIT_CLR;
        end

        WAIT_CLR: begin
          if (!matrices_loaded)
            r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_compute_ctrl.sv
// ============================================================================
// Module      : tb_matmul_compute_ctrl
// Description : Directed and randomized checks of matmul_compute_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_compute_ctrl;

  localparam int INW  = 12;
  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MAXK = 8;
  localparam int OUTW = 2 * INW + $clog2(MAXK);
  localparam int KW   = $clog2(MAXK + 1);
  localparam int AAW  = $clog2(M * MAXK);
  localparam int BAW  = $clog2(MAXK * N);
  localparam int MN   = M * N;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   matrices_loaded;
  logic [KW-1:0]          K;
  logic                   compute_finished;
  logic [AAW-1:0]         A_read_addr;
  logic signed [INW-1:0]  A_data;
  logic [BAW-1:0]         B_read_addr;
  logic signed [INW-1:0]  B_data;
  logic signed [OUTW-1:0] OUT_TDATA;
  logic                   OUT_TVALID;
  logic                   OUT_TREADY;

  logic signed [INW-1:0] a_mem [M*MAXK];
  logic signed [INW-1:0] b_mem [MAXK*N];
  longint                got   [MN];

  int total = 0;
  int bad   = 0;

  matmul_compute_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (matrices_loaded),
    .K                (K),
    .compute_finished (compute_finished),
    .A_read_addr      (A_read_addr),
    .A_data           (A_data),
    .B_read_addr      (B_read_addr),
    .B_data           (B_data),
    .OUT_TDATA        (OUT_TDATA),
    .OUT_TVALID       (OUT_TVALID),
    .OUT_TREADY       (OUT_TREADY)
  );

  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    A_data <= a_mem[A_read_addr];
    B_data <= b_mem[B_read_addr];
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fill_random();
    foreach (a_mem[x]) a_mem[x] = INW'($urandom_range(0, 4095));
    foreach (b_mem[x]) b_mem[x] = INW'($urandom_range(0, 4095));
  endtask

  task automatic run_matrix(input int kk, input int stall_idx);
    longint                 expv [MN];
    int                     idx;
    int                     pulses;
    int                     cyc;
    int                     limit;
    int                     stall_cycles;
    bit                     stalled;
    logic signed [OUTW-1:0] sd;
    logic [AAW-1:0]         sa;
    logic [BAW-1:0]         sb;

    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        expv[i*N+j] = 0;
        for (int k = 0; k < kk; k++)
          expv[i*N+j] += longint'(a_mem[i*kk+k]) * longint'(b_mem[k*N+j]);
      end

    idx          = 0;
    pulses       = 0;
    cyc          = 0;
    stalled      = 0;
    stall_cycles = (stall_idx >= 0) ? 5 : 0;
    limit        = MN * (kk + 2) + 60;
    K            = KW'(kk);
    matrices_loaded = 1'b1;

    while (cyc < limit && pulses == 0) begin
      @(negedge clk);
      cyc++;
      if (OUT_TVALID && idx == stall_idx && !stalled) begin
        stalled    = 1;
        sd         = OUT_TDATA;
        sa         = A_read_addr;
        sb         = B_read_addr;
        OUT_TREADY = 1'b0;
        repeat (5) begin
          @(negedge clk);
          cyc++;
          check("stall_tvalid", OUT_TVALID, 1);
          check("stall_tdata", OUT_TDATA, sd);
          check("stall_a_addr", A_read_addr, sa);
          check("stall_b_addr", B_read_addr, sb);
        end
        OUT_TREADY = 1'b1;
      end
      if (OUT_TVALID && OUT_TREADY) begin
        if (idx < MN) begin
          check("tdata", OUT_TDATA, expv[idx]);
          got[idx] = longint'(OUT_TDATA);
        end
        idx++;
      end
      if (compute_finished) begin
        pulses++;
        check("finish_cycle", cyc, MN * ((kk == 0) ? 1 : kk + 2) + stall_cycles + 1);
        check("result_count", idx, MN);
      end
    end
    check("finish_seen", pulses, 1);

    // matrices_loaded stays high: the same matrices must not run again.
    repeat (10) begin
      @(negedge clk);
      check("hold_no_finish", compute_finished, 0);
      check("hold_no_tvalid", OUT_TVALID, 0);
    end
    matrices_loaded = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int idx;
    int cyc;

    reset           = 1'b0;
    matrices_loaded = 1'b0;
    K               = '0;
    OUT_TREADY      = 1'b1;
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_tvalid", OUT_TVALID, 0);
    check("rst_tdata", OUT_TDATA, 0);
    check("rst_a_addr", A_read_addr, 0);
    check("rst_b_addr", B_read_addr, 0);
    check("rst_finished", compute_finished, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tvalid", OUT_TVALID, 0);

    // Small known products in the top-left corner, K=2.
    a_mem[0] = 12'sd1;  a_mem[1] = 12'sd2;
    a_mem[2] = 12'sd3;  a_mem[3] = 12'sd4;
    b_mem[0] = 12'sd5;  b_mem[1] = 12'sd6;
    b_mem[N] = 12'sd7;  b_mem[N+1] = 12'sd8;
    run_matrix(2, -1);
    check("c00", got[0], 19);
    check("c01", got[1], 22);
    check("c10", got[N], 43);
    check("c11", got[N+1], 50);

    // Most negative operands at full K.
    foreach (a_mem[x]) a_mem[x] = -12'sd2048;
    foreach (b_mem[x]) b_mem[x] = -12'sd2048;
    run_matrix(MAXK, -1);
    check("maxneg_last", got[MN-1], 33554432);

    fill_random();
    run_matrix(0, -1);
    check("k0_first", got[0], 0);

    fill_random();
    run_matrix(5, 3);

    fill_random();
    run_matrix(1, -1);

    // Reset during ISSUE of element (1,3) with K=4.
    fill_random();
    K               = KW'(4);
    matrices_loaded = 1'b1;
    idx             = 0;
    cyc             = 0;
    while (idx < 1*N+3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (OUT_TVALID && OUT_TREADY) idx++;
    end
    check("abort_reached", idx, 1*N+3);
    @(negedge clk);
    check("issue_a_addr_k0", A_read_addr, 1*4+0);
    check("issue_b_addr_k0", B_read_addr, 0*N+3);
    @(negedge clk);
    check("issue_a_addr_k1", A_read_addr, 1*4+1);
    check("issue_b_addr_k1", B_read_addr, 1*N+3);
    reset = 1'b0;
    #1;
    check("abort_tvalid", OUT_TVALID, 0);
    check("abort_tdata", OUT_TDATA, 0);
    check("abort_a_addr", A_read_addr, 0);
    check("abort_b_addr", B_read_addr, 0);
    check("abort_finished", compute_finished, 0);
    matrices_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fill_random();
    run_matrix(3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
